lane_fill_ctrl: RTL and testbench
=================================

# lane_fill_ctrl

Sequencing controller for a 4-bit-per-lane register array (8 lanes, 32 bits total). It accepts nibbles on a valid/ready stream and writes them into successive lanes, lane 0 first. It presents the packed word once all lanes are filled or a flush arrives, then holds it until the consumer takes it. It sits between a nibble-serial source and any consumer of the concatenated lane word, with lane 0 at the LSBs.

## Interface
- LANES, default 8, number of lanes; must be ≥2.
- LW, default 4, width of each lane in bits.
- CW, default $clog2(LANES+1), width of the fill count.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Asserts immediately; deassertion is synchronous to clk.
- in_valid  input  1  a nibble is offered.
- in_data  input  LW  nibble payload.
- in_ready  output  1  controller can accept a nibble this cycle.
- flush  input  1  close the current partial word; sampled only in FILL.
- out_valid  output  1  out_data/out_count hold a completed word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  LANES*LW  lane k occupies bits [k*LW +: LW].
- out_count  output  CW  number of valid lanes in out_data (1..LANES when out_valid is high).
- word_cnt  output  8  count of delivered words (out_valid && out_ready), wrapping at 256.

## Operation
- Two states: FILL and HOLD. All outputs are registered.
- Reset values: state FILL, in_ready 1, out_valid 0, out_data 0, out_count 0, word_cnt 0.
- FILL:
  - in_ready = 1, out_valid = 0.
  - An accept is in_valid && in_ready. On accept, lane[out_count] ← in_data and out_count increments.
  - If out_count becomes LANES, go to HOLD.
  - If flush is high and the post-update count is ≥1, go to HOLD. This covers flush on the same cycle as an accept: that nibble is included.
  - Flush with count 0 and no accept is ignored and stays in FILL.
  - Unwritten lanes remain 0.
- HOLD:
  - in_ready = 0, out_valid = 1. out_data and out_count are frozen.
  - flush and in_valid are ignored.
  - On out_valid && out_ready: all lanes clear to 0, out_count becomes 0, word_cnt increments (wrapping 255→0), state returns to FILL.
- No bypass: a nibble cannot be accepted in the same cycle as the HOLD→FILL handoff.
- in_data is don't-care when in_valid is low. No X may propagate into the lanes.
- An asynchronous reset mid-word discards all partial lane contents and returns every output to its reset value.

## Timing
- Accept at edge t: the lane value and out_count are visible after edge t.
- The LANES-th accept (or a flush) at edge t: out_valid = 1 and in_ready = 0 after edge t (1-cycle latency).
- Word handshake at edge t: out_valid = 0, in_ready = 1 after edge t. The next accept is possible at edge t+1.
- Maximum throughput is LANES nibbles per LANES+1 cycles when out_ready is held high.
- out_valid, once high, stays high with stable out_data and out_count until the handshake.

## Test plan
- Reset, then 8 back-to-back nibbles 1,2,…,8 with out_ready=1:
  - out_valid rises the cycle after the 8th accept, with out_data=32'h87654321 and out_count=8.
  - The word is taken the next cycle; word_cnt=1.
- Nibbles A,B, then flush alone:
  - out_data=32'h000000BA, out_count=2.
  - in_ready stays 0 until out_ready is applied.
- Nibble 5 with flush on the same cycle while count=0:
  - out_data=32'h00000005, out_count=1.
  - Flush alone with count 0 produces no output.
- Fill all 8 lanes with out_ready=0 for 10 cycles while in_valid=1 with varying data:
  - out_data stays stable and in_ready stays 0.
  - On out_ready=1, exactly one word is delivered and the next nibble lands in lane 0.
- Assert rst_n=0 asynchronously after 3 accepts:
  - out_count=0, out_data=0 and in_ready=1 immediately.
  - A subsequent full 8-nibble word is correct.
- Deliver 256 words: word_cnt wraps to 0.

Source files
------------

// File: rtl/lane_fill_ctrl.sv
// lane_fill_ctrl
//
// Collects LW-bit nibbles from a valid/ready stream into LANES lanes, lane 0
// first (lane 0 at the LSBs of out_data). The packed word is presented once
// every lane is filled or a flush closes a partial word. It is then held
// until the consumer takes it, and the lanes clear for the next word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a nibble is offered on in_data
//   in_data    nibble payload (LW bits)
//   in_ready   controller accepts a nibble this cycle (FILL state)
//   flush      close the current partial word (only looked at in FILL)
//   out_valid  out_data/out_count hold a completed word (HOLD state)
//   out_ready  consumer accepts the word
//   out_data   packed lanes, lane k at [k*LW +: LW]
//   out_count  number of valid lanes in out_data
//   word_cnt   delivered-word counter, wraps at 256

module lane_fill_ctrl #(
    parameter int LANES = 8,
    parameter int LW    = 4,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [LW-1:0]       in_data,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*LW-1:0] out_data,
    output logic [CW-1:0]       out_count,
    output logic [7:0]          word_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(LANES);

    state_t                state_q, state_d;
    logic [LANES*LW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]         out_count_q, out_count_d;
    logic [7:0]            word_cnt_q, word_cnt_d;

    // in_ready/out_valid are pure decodes of the state flop, so they are
    // still registered outputs without a redundant pair of flops.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign word_cnt  = word_cnt_q;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    // Lane write decoded per lane; in_data is only sampled on
                    // an accept, so an X on an idle bus never reaches a lane.
                    for (int k = 0; k < LANES; k++) begin
                        if (out_count_q == CW'(k)) begin
                            out_data_d[k*LW +: LW] = in_data;
                        end
                    end
                    out_count_d = out_count_q + CW'(1);
                end
                // Flush uses the post-update count so a nibble accepted on
                // the flush cycle is part of the closed word.
                if ((out_count_d == FULL_COUNT) ||
                    (flush && (out_count_d != '0))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_data_d  = '0;
                    out_count_d = '0;
                    word_cnt_d  = word_cnt_q + 8'd1;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            out_data_q  <= '0;
            out_count_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_lane_fill_ctrl.sv
// tb_lane_fill_ctrl
//
// Directed and randomized stimulus for lane_fill_ctrl. The reference model
// keeps the current word as a queue of accepted nibbles plus a held flag and
// a delivered-word count; expected outputs are derived from that queue.

module tb_lane_fill_ctrl;

    localparam int LANES = 8;
    localparam int LW    = 4;
    localparam int CW    = $clog2(LANES + 1);

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic [LW-1:0]       in_data;
    logic                in_ready;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*LW-1:0] out_data;
    logic [CW-1:0]       out_count;
    logic [7:0]          word_cnt;

    lane_fill_ctrl #(.LANES(LANES), .LW(LW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .word_cnt  (word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [LW-1:0] mLanes[$];
    bit            mHold;
    int            mWords;

    task automatic modelReset();
        mLanes.delete();
        mHold  = 1'b0;
        mWords = 0;
    endtask

    task automatic modelStep(input logic v, input logic [LW-1:0] d,
                             input logic f, input logic r);
        if (!mHold) begin
            if (v) mLanes.push_back(d);
            if (mLanes.size() == LANES || (f && mLanes.size() >= 1)) mHold = 1'b1;
        end else if (r) begin
            mLanes.delete();
            mHold  = 1'b0;
            mWords = (mWords + 1) % 256;
        end
    endtask

    function automatic logic [LANES*LW-1:0] modelWord();
        logic [LANES*LW-1:0] w = '0;
        foreach (mLanes[i]) w = w | ((LANES*LW)'(mLanes[i]) << (LW * i));
        return w;
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("in_ready",  32'(in_ready),  32'(!mHold));
        checkOne("out_valid", 32'(out_valid), 32'(mHold));
        checkOne("out_data",  32'(out_data),  32'(modelWord()));
        checkOne("out_count", 32'(out_count), 32'(mLanes.size()));
        checkOne("word_cnt",  32'(word_cnt),  32'(mWords));
    endtask

    // Drive one cycle of inputs, step the model on the edge, check after it.
    task automatic applyStimulus(input logic v, input logic [LW-1:0] d,
                                 input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        modelStep(v, d, f, r);
        #1;
        checkOutput();
    endtask

    initial begin
        int budget;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #12;
        $display("[TB] reset state");
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] full word 1..8");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, LW'(i), 1'b0, 1'b1);
        checkOne("full_word_const", out_data, 32'h87654321);
        checkOne("full_count_const", 32'(out_count), 32'd8);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkOne("word_cnt_after_first", 32'(word_cnt), 32'd1);

        $display("[TB] partial word A,B then flush");
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOne("flush_word_const", out_data, 32'h000000BA);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, LW'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

        $display("[TB] flush with empty word, then 5 with flush");
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
        checkOne("flush_accept_const", out_data, 32'h00000005);
        checkOne("flush_accept_count", 32'(out_count), 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

        $display("[TB] backpressure while full");
        for (int i = 0; i < LANES; i++) applyStimulus(1'b1, LW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, LW'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b1);
        checkOne("lane0_after_handoff", out_data, 32'h00000003);

        $display("[TB] async reset mid-word");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, LW'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LANES; i++) applyStimulus(1'b1, LW'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), LW'($urandom),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] word counter wrap");
        budget = 1200;
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        while (mWords != 0 && budget > 0) begin
            applyStimulus(1'b1, LW'($urandom), 1'b1, 1'b1);
            budget--;
        end
        checkOne("wrap_budget", 32'(budget > 0), 32'd1);
        checkOne("word_cnt_wrapped", 32'(word_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
